// File: rtl/mem_port_arbiter.sv
// Single-SRAM arbiter between instruction fetch and MEM-stage data access, plus global pipeline stall.
// Optional build macro ARB_PERF_EN adds saturating stall/conflict performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              pipe_en,
    output logic              memwb_bubble
`ifdef ARB_PERF_EN
   ,output logic [15:0]       stall_cnt,
    output logic [15:0]       mem_conflicts
`endif
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, WR_REC, DONE} state_t;

    localparam logic [3:0] ACC = 4'(ACCESS_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic       lastMem;
    logic       grantMem;
    logic       stall;

    // MEM wins a tie unless the previous completed access already went to MEM.
    assign grantMem     = mem_req & ~(if_req & lastMem);
    assign stall        = (if_req & ~if_ready) | (mem_req & ~mem_ready);
    assign pipe_en      = ~stall;
    assign memwb_bubble = stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lastMem    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || mem_req) begin
                        cnt       <= ACC;
                        sram_ce_n <= 1'b0;
                        if (grantMem) begin
                            sram_addr  <= mem_addr;
                            sram_wdata <= mem_wdata;
                            if (mem_wr) begin
                                state     <= MEM_WR;
                                sram_we_n <= 1'b0;
                            end else begin
                                state     <= MEM_RD;
                                sram_oe_n <= 1'b0;
                            end
                        end else begin
                            sram_addr <= if_addr;
                            sram_oe_n <= 1'b0;
                            state     <= IF_RD;
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    if (cnt == 4'd1) begin
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        state     <= DONE;
                        if (state == MEM_RD) begin
                            mem_rdata <= sram_rdata;
                            mem_ready <= 1'b1;
                        end else begin
                            if_rdata <= sram_rdata;
                            if_ready <= 1'b1;
                        end
                    end
                    cnt <= cnt - 4'd1;
                end
                MEM_WR: begin
                    // Release we_n one cycle before ce_n so addr/data hold past the write edge.
                    if (cnt == 4'd1) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_REC;
                    end
                    cnt <= cnt - 4'd1;
                end
                WR_REC: begin
                    sram_ce_n <= 1'b1;
                    mem_ready <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    lastMem   <= mem_ready;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt     <= '0;
            mem_conflicts <= '0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (state == IDLE && if_req && mem_req && mem_conflicts != 16'hFFFF)
                mem_conflicts <= mem_conflicts + 16'd1;
        end
    end
`endif

endmodule
